// File: rtl/raw10_unpacker_if.sv
// raw10_unpacker_if: bundles the stripped-payload input stream from
// pckthandler and the unpacked pixel-pair output stream.
//   din/din_valid         16-bit payload word and its qualifier
//   fr_active_in          frame-active from pckthandler
//   fr_valid_in           line/payload-valid, high across one packet payload
//   pix0/pix1/pix_valid   earlier/later 10-bit pixel of a pair and qualifier
//   fr_active_out         fr_active_in delayed one cycle
//   line_end/err_partial  end-of-line and mid-group-end pulses
// slave  = unpacker side (consumes words, produces pixels)
// master = source/sink side (drives words, observes pixels)
interface raw10_unpacker_if;
  logic [15:0] din;
  logic        din_valid;
  logic        fr_active_in;
  logic        fr_valid_in;
  logic [9:0]  pix0;
  logic [9:0]  pix1;
  logic        pix_valid;
  logic        fr_active_out;
  logic        line_end;
  logic        err_partial;

  modport slave (
    input  din, din_valid, fr_active_in, fr_valid_in,
    output pix0, pix1, pix_valid, fr_active_out, line_end, err_partial
  );

  modport master (
    output din, din_valid, fr_active_in, fr_valid_in,
    input  pix0, pix1, pix_valid, fr_active_out, line_end, err_partial
  );
endinterface

// File: rtl/raw10_unpacker.sv
// raw10_unpacker: unpacks MIPI RAW10 (5 bytes -> 4 pixels) from the 16-bit
// payload word stream into pairs of 10-bit pixels, tracks line ends and
// flags lines that end in the middle of a group.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    raw10_unpacker_if.slave (payload in, pixel pairs out)
// FIRST_BYTE_HI: 1 = din[15:8] is the earlier wire byte, 0 = din[7:0].
//
// phase | meaning (word about to be accepted carries)
// 0     | B0,B1
// 1     | B2,B3
// 2     | B4,B5  (completes group A)
// 3     | B6,B7
// 4     | B8,B9  (completes group B)
module raw10_unpacker #(
  parameter bit FIRST_BYTE_HI = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  raw10_unpacker_if.slave bus
);

  logic [2:0]  phase_q, phase_d;
  logic [7:0]  b_early, b_late;
  logic        accept;
  logic        complete_a, complete_b;
  logic        fr_valid_q;
  logic        line_fall;
  logic        end_q;
  logic [31:0] buf_a;     // B0..B3
  logic [23:0] buf_b;     // B5..B7
  logic        pend_q;
  logic [19:0] pend_pair_q;

  logic        pix_valid_d, pend_d;
  logic [9:0]  pix0_d, pix1_d;
  logic [19:0] pend_pair_d;
  logic        err_d;

  assign b_early   = FIRST_BYTE_HI ? bus.din[15:8] : bus.din[7:0];
  assign b_late    = FIRST_BYTE_HI ? bus.din[7:0]  : bus.din[15:8];
  assign accept    = bus.din_valid & bus.fr_valid_in;
  assign line_fall = fr_valid_q & ~bus.fr_valid_in;
  assign complete_a = accept && (phase_q == 3'd2);
  assign complete_b = accept && (phase_q == 3'd4);

  // state register
  always_ff @(posedge clk) begin
    if (reset) phase_q <= 3'd0;
    else       phase_q <= phase_d;
  end

  // next phase: dropping fr_valid_in discards any partial group
  always_comb begin
    phase_d = phase_q;
    if (!bus.fr_valid_in)  phase_d = 3'd0;
    else if (accept)       phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
  end

  // output decode; a pending pair never coincides with a group completion
  always_comb begin
    pix_valid_d = 1'b0;
    pix0_d      = 10'd0;
    pix1_d      = 10'd0;
    pend_d      = 1'b0;
    pend_pair_d = 20'd0;
    if (complete_a) begin
      // g0..g3 = buf_a bytes, g4 = B4 = b_early
      pix_valid_d = 1'b1;
      pix0_d      = {buf_a[31:24], b_early[1:0]};
      pix1_d      = {buf_a[23:16], b_early[3:2]};
      pend_d      = 1'b1;
      pend_pair_d = {buf_a[15:8], b_early[5:4], buf_a[7:0], b_early[7:6]};
    end else if (complete_b) begin
      // g0..g2 = buf_b bytes, g3 = B8 = b_early, g4 = B9 = b_late
      pix_valid_d = 1'b1;
      pix0_d      = {buf_b[23:16], b_late[1:0]};
      pix1_d      = {buf_b[15:8],  b_late[3:2]};
      pend_d      = 1'b1;
      pend_pair_d = {buf_b[7:0], b_late[5:4], b_early, b_late[7:6]};
    end else if (pend_q) begin
      pix_valid_d = 1'b1;
      pix0_d      = pend_pair_q[19:10];
      pix1_d      = pend_pair_q[9:0];
    end
  end

  // phase 3 at line end is legal: B5 was padding
  assign err_d = line_fall &&
                 ((phase_q == 3'd1) || (phase_q == 3'd2) || (phase_q == 3'd4));

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_a             <= 32'd0;
      buf_b             <= 24'd0;
      pend_q            <= 1'b0;
      pend_pair_q       <= 20'd0;
      fr_valid_q        <= 1'b0;
      end_q             <= 1'b0;
      bus.pix0          <= 10'd0;
      bus.pix1          <= 10'd0;
      bus.pix_valid     <= 1'b0;
      bus.fr_active_out <= 1'b0;
      bus.line_end      <= 1'b0;
      bus.err_partial   <= 1'b0;
    end else begin
      if (accept) begin
        case (phase_q)
          3'd0:    buf_a[31:16] <= {b_early, b_late};
          3'd1:    buf_a[15:0]  <= {b_early, b_late};
          3'd2:    buf_b[23:16] <= b_late;
          3'd3:    buf_b[15:0]  <= {b_early, b_late};
          default: ;
        endcase
      end
      pend_q            <= pend_d;
      pend_pair_q       <= pend_pair_d;
      fr_valid_q        <= bus.fr_valid_in;
      // line_end trails the fall by one extra edge so the pending pair drains first
      end_q             <= line_fall;
      bus.pix0          <= pix0_d;
      bus.pix1          <= pix1_d;
      bus.pix_valid     <= pix_valid_d;
      bus.fr_active_out <= bus.fr_active_in;
      bus.line_end      <= end_q;
      bus.err_partial   <= err_d;
    end
  end

endmodule

// File: tb/tb_raw10_unpacker.sv
// tb_raw10_unpacker: directed bench for raw10_unpacker. Two instances run in
// lockstep: FIRST_BYTE_HI=1 fed the reference words, FIRST_BYTE_HI=0 fed the
// byte-swapped words; both must produce the same hand-computed pixel stream.
module tb_raw10_unpacker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  raw10_unpacker_if ifh ();
  raw10_unpacker_if ifl ();

  raw10_unpacker #(.FIRST_BYTE_HI(1'b1)) dut_hi (.clk(clk), .reset(reset), .bus(ifh));
  raw10_unpacker #(.FIRST_BYTE_HI(1'b0)) dut_lo (.clk(clk), .reset(reset), .bus(ifl));

  // bytes 01 02 03 04 E4 | 05 06 07 08 1B
  // A: g4=E4 -> P0={01,00} P1={02,01} P2={03,10} P3={04,11}
  // B: g4=1B -> P0={05,11} P1={06,10} P2={07,01} P3={08,00}
  localparam logic [9:0] A0 = 10'h004, A1 = 10'h009, A2 = 10'h00E, A3 = 10'h013;
  localparam logic [9:0] B0 = 10'h017, B1 = 10'h01A, B2 = 10'h01D, B3 = 10'h020;

  logic [15:0] w [5];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic fa;
  logic fa_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic dv, input logic fv, input logic [15:0] wd);
    ifh.din_valid    = dv;  ifl.din_valid    = dv;
    ifh.fr_valid_in  = fv;  ifl.fr_valid_in  = fv;
    ifh.fr_active_in = fa;  ifl.fr_active_in = fa;
    ifh.din = wd;
    ifl.din = {wd[7:0], wd[15:8]};
    fa_exp = reset ? 1'b0 : fa;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic pv, input logic [9:0] p0,
                            input logic [9:0] p1, input logic le, input logic ep);
    chk({tag, ".hi.pv"}, ifh.pix_valid, pv);
    chk({tag, ".lo.pv"}, ifl.pix_valid, pv);
    if (pv) begin
      chk({tag, ".hi.p0"}, ifh.pix0, p0);
      chk({tag, ".hi.p1"}, ifh.pix1, p1);
      chk({tag, ".lo.p0"}, ifl.pix0, p0);
      chk({tag, ".lo.p1"}, ifl.pix1, p1);
    end
    chk({tag, ".hi.le"}, ifh.line_end, le);
    chk({tag, ".lo.le"}, ifl.line_end, le);
    chk({tag, ".hi.ep"}, ifh.err_partial, ep);
    chk({tag, ".lo.ep"}, ifl.err_partial, ep);
    chk({tag, ".hi.fa"}, ifh.fr_active_out, fa_exp);
    chk({tag, ".lo.fa"}, ifl.fr_active_out, fa_exp);
  endtask

  // full 5-word line at full rate, then close it and check the end pulses
  task automatic full_line(input string tag);
    drive(1, 1, w[0]); expect_out({tag, ".w0"}, 0, 0, 0, 0, 0);
    drive(1, 1, w[1]); expect_out({tag, ".w1"}, 0, 0, 0, 0, 0);
    drive(1, 1, w[2]); expect_out({tag, ".a01"}, 1, A0, A1, 0, 0);
    drive(1, 1, w[3]); expect_out({tag, ".a23"}, 1, A2, A3, 0, 0);
    drive(1, 1, w[4]); expect_out({tag, ".b01"}, 1, B0, B1, 0, 0);
    drive(1, 0, 16'hFFFF); expect_out({tag, ".b23"}, 1, B2, B3, 0, 0);
    drive(1, 0, 16'hAAAA); expect_out({tag, ".le"}, 0, 0, 0, 1, 0);
    drive(0, 0, 16'h0000); expect_out({tag, ".idle"}, 0, 0, 0, 0, 0);
  endtask

  initial begin
    w[0] = 16'h0102; w[1] = 16'h0304; w[2] = 16'hE405; w[3] = 16'h0607; w[4] = 16'h081B;
    reset = 1'b1;
    fa    = 1'b0;
    drive(0, 0, 16'h0000);
    drive(1, 1, 16'h1234);
    expect_out("rst", 0, 0, 0, 0, 0);
    chk("rst.hi.p0", ifh.pix0, 10'd0);
    chk("rst.lo.p1", ifl.pix1, 10'd0);
    reset = 1'b0;
    fa    = 1'b1;
    drive(0, 0, 16'h0000); expect_out("pre", 0, 0, 0, 0, 0);

    full_line("cont");

    // alternate din_valid gaps: partner pairs still drain on the next edge
    drive(1, 1, w[0]);     expect_out("alt.w0", 0, 0, 0, 0, 0);
    drive(0, 1, 16'hDEAD); expect_out("alt.g0", 0, 0, 0, 0, 0);
    drive(1, 1, w[1]);     expect_out("alt.w1", 0, 0, 0, 0, 0);
    drive(0, 1, 16'hDEAD); expect_out("alt.g1", 0, 0, 0, 0, 0);
    drive(1, 1, w[2]);     expect_out("alt.a01", 1, A0, A1, 0, 0);
    drive(0, 1, 16'hDEAD); expect_out("alt.a23", 1, A2, A3, 0, 0);
    drive(1, 1, w[3]);     expect_out("alt.w3", 0, 0, 0, 0, 0);
    drive(0, 1, 16'hDEAD); expect_out("alt.g3", 0, 0, 0, 0, 0);
    drive(1, 1, w[4]);     expect_out("alt.b01", 1, B0, B1, 0, 0);
    drive(0, 1, 16'hDEAD); expect_out("alt.b23", 1, B2, B3, 0, 0);
    drive(0, 0, 16'h0000); expect_out("alt.fall", 0, 0, 0, 0, 0);
    drive(0, 0, 16'h0000); expect_out("alt.le", 0, 0, 0, 1, 0);
    drive(0, 0, 16'h0000); expect_out("alt.idle", 0, 0, 0, 0, 0);

    // 3-word line: group A plus one padding byte, legal end
    drive(1, 1, w[0]); expect_out("w3l.w0", 0, 0, 0, 0, 0);
    drive(1, 1, w[1]); expect_out("w3l.w1", 0, 0, 0, 0, 0);
    drive(1, 1, w[2]); expect_out("w3l.a01", 1, A0, A1, 0, 0);
    drive(0, 0, 16'h0000); expect_out("w3l.a23", 1, A2, A3, 0, 0);
    drive(0, 0, 16'h0000); expect_out("w3l.le", 0, 0, 0, 1, 0);
    drive(0, 0, 16'h0000); expect_out("w3l.idle", 0, 0, 0, 0, 0);

    // 4-word line: group B incomplete -> err_partial
    drive(1, 1, w[0]); expect_out("w4l.w0", 0, 0, 0, 0, 0);
    drive(1, 1, w[1]); expect_out("w4l.w1", 0, 0, 0, 0, 0);
    drive(1, 1, w[2]); expect_out("w4l.a01", 1, A0, A1, 0, 0);
    drive(1, 1, w[3]); expect_out("w4l.a23", 1, A2, A3, 0, 0);
    drive(0, 0, 16'h0000); expect_out("w4l.err", 0, 0, 0, 0, 1);
    drive(0, 0, 16'h0000); expect_out("w4l.le", 0, 0, 0, 1, 0);
    drive(0, 0, 16'h0000); expect_out("w4l.idle", 0, 0, 0, 0, 0);

    // 1-word line: mid-group end at phase 1
    drive(1, 1, w[0]); expect_out("w1l.w0", 0, 0, 0, 0, 0);
    drive(0, 0, 16'h0000); expect_out("w1l.err", 0, 0, 0, 0, 1);
    drive(0, 0, 16'h0000); expect_out("w1l.le", 0, 0, 0, 1, 0);

    // reset on the cycle the pending A pair is due
    drive(1, 1, w[0]); expect_out("rml.w0", 0, 0, 0, 0, 0);
    drive(1, 1, w[1]); expect_out("rml.w1", 0, 0, 0, 0, 0);
    drive(1, 1, w[2]); expect_out("rml.a01", 1, A0, A1, 0, 0);
    reset = 1'b1;
    drive(0, 1, 16'h0000); expect_out("rml.rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 16'h0000); expect_out("rml.q0", 0, 0, 0, 0, 0);
    drive(0, 0, 16'h0000); expect_out("rml.q1", 0, 0, 0, 0, 0);
    drive(0, 0, 16'h0000); expect_out("rml.q2", 0, 0, 0, 0, 0);
    full_line("post");

    fa = 1'b0;
    drive(0, 0, 16'h0000); expect_out("fa.low", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
